// File: rtl/commit_trace_serializer_if.sv
// Retire-side and trace-side signals of the commit trace serializer.
// The master is the core/monitor harness; the slave is the serializer itself.
interface commit_trace_serializer_if #(
  parameter int unsigned NRET  = 2,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned SW = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int unsigned OW = $clog2(DEPTH) + 1;

  logic [NRET-1:0]      in_valid;
  logic [NRET*XLEN-1:0] in_pc;
  logic [NRET*32-1:0]   in_insn;
  logic                 in_trap_valid;
  logic [XLEN-1:0]      in_trap_code;
  logic                 in_halt;
  logic                 in_ready;

  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [31:0]          out_insn;
  logic                 out_insn_valid;
  logic [SW-1:0]        out_slot;
  logic [XLEN-1:0]      out_seq;
  logic                 out_trap_valid;
  logic [XLEN-1:0]      out_trap_code;

  logic [OW-1:0]        occupancy;
  logic                 done;
  logic                 overflow;

  modport master (
    output in_valid, in_pc, in_insn, in_trap_valid, in_trap_code, in_halt, out_ready,
    input  in_ready, out_valid, out_pc, out_insn, out_insn_valid, out_slot, out_seq,
           out_trap_valid, out_trap_code, occupancy, done, overflow
  );

  modport slave (
    input  in_valid, in_pc, in_insn, in_trap_valid, in_trap_code, in_halt, out_ready,
    output in_ready, out_valid, out_pc, out_insn, out_insn_valid, out_slot, out_seq,
           out_trap_valid, out_trap_code, occupancy, done, overflow
  );
endinterface

// File: rtl/commit_trace_serializer.sv
// Buffers NRET-wide retire bundles and replays them one instruction per cycle,
// tagged with slot, sequence number and trap info; drains on halt before done.
module commit_trace_serializer #(
  parameter int unsigned NRET  = 2,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  commit_trace_serializer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned OW = AW + 1;
  localparam int unsigned SW = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int unsigned CW = $clog2(NRET + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
    logic            insnValid;
    logic [SW-1:0]   slot;
    logic            trapValid;
    logic [XLEN-1:0] trapCode;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          pushEntry [NRET+1];
  entry_t          head;
  logic [CW-1:0]   pushCnt;
  logic [AW-1:0]   wrPtr;
  logic [AW-1:0]   rdPtr;
  logic [OW-1:0]   occ;
  logic [OW-1:0]   occNext;
  logic [OW-1:0]   freeCnt;
  logic [XLEN-1:0] seq;
  logic            haltSeen;
  logic            haltNext;
  logic            doneQ;
  logic            overflowQ;
  logic            presented;
  logic            ready;
  logic            accept;
  logic            outValid;
  logic            pop;

  // Compact valid slots in ascending order; trap rides on the youngest entry.
  always_comb begin
    pushCnt = '0;
    for (int k = 0; k <= int'(NRET); k++) pushEntry[k] = '0;
    for (int i = 0; i < int'(NRET); i++) begin
      if (bus.in_valid[i]) begin
        pushEntry[pushCnt].pc        = bus.in_pc[i*XLEN +: XLEN];
        pushEntry[pushCnt].insn      = bus.in_insn[i*32 +: 32];
        pushEntry[pushCnt].insnValid = 1'b1;
        pushEntry[pushCnt].slot      = SW'(i);
        pushCnt = pushCnt + CW'(1);
      end
    end
    if (bus.in_trap_valid) begin
      if (pushCnt == '0) begin
        pushEntry[0].trapValid = 1'b1;
        pushEntry[0].trapCode  = bus.in_trap_code;
        pushCnt = CW'(1);
      end else begin
        pushEntry[pushCnt - CW'(1)].trapValid = 1'b1;
        pushEntry[pushCnt - CW'(1)].trapCode  = bus.in_trap_code;
      end
    end
  end

  // Credit comes from registered occupancy only; a same-cycle pop frees nothing.
  always_comb begin
    freeCnt   = OW'(DEPTH) - occ;
    ready     = !rst && !haltSeen && (freeCnt >= OW'(NRET));
    presented = (|bus.in_valid) || bus.in_trap_valid;
    accept    = presented && ready;
    outValid  = (occ != '0);
    head      = mem[rdPtr];
    pop       = outValid && bus.out_ready;
    occNext   = occ + (accept ? OW'(pushCnt) : OW'(0)) - OW'(pop);
    haltNext  = haltSeen || bus.in_halt;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < int'(NRET); k++) begin
        if (CW'(k) < pushCnt) mem[wrPtr + AW'(k)] <= pushEntry[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      occ       <= '0;
      seq       <= '0;
      haltSeen  <= 1'b0;
      doneQ     <= 1'b0;
      overflowQ <= 1'b0;
    end else begin
      wrPtr     <= wrPtr + (accept ? AW'(pushCnt) : AW'(0));
      rdPtr     <= rdPtr + AW'(pop);
      occ       <= occNext;
      haltSeen  <= haltNext;
      overflowQ <= overflowQ || (presented && !ready);
      doneQ     <= doneQ || (haltNext && (occNext == '0));
      // Trap-only entries report the sequence number but do not consume it.
      if (pop && head.insnValid) seq <= seq + XLEN'(1);
    end
  end

  // Payload is forced to zero whenever nothing is held, so reset clears it at once.
  always_comb begin
    bus.in_ready       = ready;
    bus.out_valid      = outValid;
    bus.out_pc         = outValid ? head.pc        : '0;
    bus.out_insn       = outValid ? head.insn      : '0;
    bus.out_insn_valid = outValid && head.insnValid;
    bus.out_slot       = outValid ? head.slot      : '0;
    bus.out_seq        = outValid ? seq            : '0;
    bus.out_trap_valid = outValid && head.trapValid;
    bus.out_trap_code  = outValid ? head.trapCode  : '0;
    bus.occupancy      = occ;
    bus.done           = doneQ;
    bus.overflow       = overflowQ;
  end
endmodule

// File: tb/tb_commit_trace_serializer.sv
// Directed bench: a NRET=2/XLEN=64/DEPTH=8 instance for the main behaviour and
// a 4-bit XLEN instance to reach the sequence-counter wrap.
module tb_commit_trace_serializer;
  logic clk;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;

  commit_trace_serializer_if #(.NRET(2), .XLEN(64), .DEPTH(8)) busA ();
  commit_trace_serializer_if #(.NRET(2), .XLEN(4),  .DEPTH(8)) busB ();

  commit_trace_serializer #(.NRET(2), .XLEN(64), .DEPTH(8)) dutA (
    .clk(clk), .rst(rst), .bus(busA)
  );
  commit_trace_serializer #(.NRET(2), .XLEN(4), .DEPTH(8)) dutB (
    .clk(clk), .rst(rst), .bus(busB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearA();
    busA.in_valid      = '0;
    busA.in_pc         = '0;
    busA.in_insn       = '0;
    busA.in_trap_valid = 1'b0;
    busA.in_trap_code  = '0;
    busA.in_halt       = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clearA();
    busA.out_ready     = 1'b0;
    busB.in_valid      = '0;
    busB.in_pc         = '0;
    busB.in_insn       = '0;
    busB.in_trap_valid = 1'b0;
    busB.in_trap_code  = '0;
    busB.in_halt       = 1'b0;
    busB.out_ready     = 1'b0;
    #1;
    chk("rst_in_ready", 64'(busA.in_ready), 64'd0);
    chk("rst_out_valid", 64'(busA.out_valid), 64'd0);
    chk("rst_occupancy", 64'(busA.occupancy), 64'd0);
    chk("rst_done", 64'(busA.done), 64'd0);
    chk("rst_overflow", 64'(busA.overflow), 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(busA.in_ready), 64'd1);

    // Full bundle, consumer always ready
    busA.out_ready = 1'b1;
    busA.in_valid  = 2'b11;
    busA.in_pc     = {64'h1004, 64'h1000};
    busA.in_insn   = {32'h33, 32'h13};
    #1;
    chk("no_bypass", 64'(busA.out_valid), 64'd0);
    step();
    clearA();
    chk("t1_valid", 64'(busA.out_valid), 64'd1);
    chk("t1_pc0", busA.out_pc, 64'h1000);
    chk("t1_insn0", 64'(busA.out_insn), 64'h13);
    chk("t1_slot0", 64'(busA.out_slot), 64'd0);
    chk("t1_seq0", busA.out_seq, 64'd0);
    chk("t1_occ2", 64'(busA.occupancy), 64'd2);
    step();
    chk("t1_pc1", busA.out_pc, 64'h1004);
    chk("t1_insn1", 64'(busA.out_insn), 64'h33);
    chk("t1_slot1", 64'(busA.out_slot), 64'd1);
    chk("t1_seq1", busA.out_seq, 64'd1);
    step();
    chk("t1_empty", 64'(busA.out_valid), 64'd0);

    // Sparse mask with trap, then trap-only bundle
    busA.in_valid      = 2'b10;
    busA.in_pc         = {64'h2000, 64'h0};
    busA.in_insn       = {32'h73, 32'h0};
    busA.in_trap_valid = 1'b1;
    busA.in_trap_code  = 64'h2;
    step();
    chk("t2_slot", 64'(busA.out_slot), 64'd1);
    chk("t2_pc", busA.out_pc, 64'h2000);
    chk("t2_ivalid", 64'(busA.out_insn_valid), 64'd1);
    chk("t2_tvalid", 64'(busA.out_trap_valid), 64'd1);
    chk("t2_tcode", busA.out_trap_code, 64'h2);
    chk("t2_seq", busA.out_seq, 64'd2);
    busA.in_valid      = 2'b00;
    busA.in_pc         = '0;
    busA.in_insn       = '0;
    busA.in_trap_code  = 64'h8;
    step();
    clearA();
    chk("t2b_ivalid", 64'(busA.out_insn_valid), 64'd0);
    chk("t2b_pc", busA.out_pc, 64'h0);
    chk("t2b_insn", 64'(busA.out_insn), 64'h0);
    chk("t2b_slot", 64'(busA.out_slot), 64'd0);
    chk("t2b_tvalid", 64'(busA.out_trap_valid), 64'd1);
    chk("t2b_tcode", busA.out_trap_code, 64'h8);
    chk("t2b_seq", busA.out_seq, 64'd3);
    step();
    chk("t2b_empty", 64'(busA.occupancy), 64'd0);

    // Backpressure until full, then a dropped bundle
    busA.out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      busA.in_valid = 2'b11;
      busA.in_pc    = {64'(64'h3004 + 8*b), 64'(64'h3000 + 8*b)};
      busA.in_insn  = {32'(2*b + 1), 32'(2*b)};
      step();
    end
    chk("t3_occ8", 64'(busA.occupancy), 64'd8);
    chk("t3_not_ready", 64'(busA.in_ready), 64'd0);
    chk("t3_no_ovf_yet", 64'(busA.overflow), 64'd0);
    busA.in_pc = {64'h9004, 64'h9000};
    step();
    clearA();
    chk("t3_overflow", 64'(busA.overflow), 64'd1);
    chk("t3_occ_stays", 64'(busA.occupancy), 64'd8);
    chk("t3_hold_pc", busA.out_pc, 64'h3000);
    busA.out_ready = 1'b1;
    for (int e = 0; e < 8; e++) begin
      chk($sformatf("t3_pc%0d", e), busA.out_pc, 64'(64'h3000 + 4*e));
      chk($sformatf("t3_insn%0d", e), 64'(busA.out_insn), 64'(e));
      chk($sformatf("t3_seq%0d", e), busA.out_seq, 64'(3 + e));
      step();
    end
    chk("t3_drained", 64'(busA.occupancy), 64'd0);
    chk("t3_ovf_sticky", 64'(busA.overflow), 64'd1);

    // Halt with three entries buffered
    doReset();
    chk("t4_ovf_cleared", 64'(busA.overflow), 64'd0);
    busA.out_ready = 1'b0;
    busA.in_valid  = 2'b11;
    busA.in_pc     = {64'h4004, 64'h4000};
    step();
    busA.in_valid  = 2'b01;
    busA.in_pc     = {64'h0, 64'h4008};
    step();
    clearA();
    busA.in_halt = 1'b1;
    step();
    busA.in_halt = 1'b0;
    chk("t4_occ3", 64'(busA.occupancy), 64'd3);
    chk("t4_halt_ready", 64'(busA.in_ready), 64'd0);
    chk("t4_done_early", 64'(busA.done), 64'd0);
    busA.in_valid = 2'b01;
    step();
    clearA();
    chk("t4_overflow", 64'(busA.overflow), 64'd1);
    chk("t4_occ_kept", 64'(busA.occupancy), 64'd3);
    busA.out_ready = 1'b1;
    chk("t4_first_pc", busA.out_pc, 64'h4000);
    step();
    step();
    chk("t4_done_pending", 64'(busA.done), 64'd0);
    chk("t4_last_pc", busA.out_pc, 64'h4008);
    step();
    chk("t4_done", 64'(busA.done), 64'd1);
    chk("t4_empty", 64'(busA.occupancy), 64'd0);
    step();
    chk("t4_done_sticky", 64'(busA.done), 64'd1);

    // Asynchronous reset with five entries held
    doReset();
    chk("t5_done_cleared", 64'(busA.done), 64'd0);
    busA.out_ready = 1'b0;
    busA.in_valid  = 2'b11;
    busA.in_pc     = {64'h7004, 64'h7000};
    step();
    step();
    busA.in_valid  = 2'b01;
    step();
    clearA();
    chk("t5_occ5", 64'(busA.occupancy), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_ar_valid", 64'(busA.out_valid), 64'd0);
    chk("t5_ar_occ", 64'(busA.occupancy), 64'd0);
    chk("t5_ar_ready", 64'(busA.in_ready), 64'd0);
    chk("t5_ar_pc", busA.out_pc, 64'h0);
    step();
    rst = 1'b0;
    busA.in_valid = 2'b01;
    busA.in_pc    = {64'h0, 64'h5000};
    step();
    clearA();
    chk("t5_new_occ", 64'(busA.occupancy), 64'd1);
    chk("t5_new_seq", busA.out_seq, 64'd0);
    chk("t5_new_pc", busA.out_pc, 64'h5000);

    // Sequence wrap on the 4-bit instance, then halt while empty
    busB.out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      busB.in_valid = 2'b01;
      busB.in_pc    = {4'h0, 4'(k)};
      step();
      chk($sformatf("t6_seq%0d", k), 64'(busB.out_seq), 64'(k % 16));
      chk($sformatf("t6_pc%0d", k), 64'(busB.out_pc), 64'(k % 16));
    end
    busB.in_valid = 2'b00;
    step();
    chk("t6_empty", 64'(busB.occupancy), 64'd0);
    chk("t6_not_done", 64'(busB.done), 64'd0);
    busB.in_halt = 1'b1;
    step();
    busB.in_halt = 1'b0;
    chk("t6_done_empty_halt", 64'(busB.done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
